// File: rtl/nms_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle for the NMS window controller.
// The controller sits on the slave modport; the pixel source and window consumer use master.
interface nms_window_ctrl_if #(
  parameter int XW = 11,
  parameter int YW = 11
) ();
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic [XW-1:0] out_cx;
  logic [YW-1:0] out_cy;

  modport master (output in_valid, input in_ready, out_valid, out_cx, out_cy);
  modport slave  (input in_valid, output in_ready, out_valid, out_cx, out_cy);
endinterface

// File: rtl/nms_window_ctrl.sv
// Frame sequencer for the NMS 3-row window datapath: raster intake, flush and interior tagging.
// Optional NMS_CTRL_STATS_EN adds frame_cnt / stall_cnt statistics outputs.
module nms_window_ctrl #(
  parameter int IMG_W     = 1920,
  parameter int IMG_H     = 1080,
  parameter int ALIGN_LAT = 2,
  parameter int XW        = 11,
  parameter int YW        = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  nms_window_ctrl_if.slave     bus,
  output logic                 lb_enable,
  output logic                 lb_zero,
  output logic                 busy,
  output logic                 frame_done
`ifdef NMS_CTRL_STATS_EN
  ,
  output logic [15:0]          frame_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int FW = (ALIGN_LAT > 1) ? $clog2(ALIGN_LAT) : 1;
  localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);
  localparam logic [FW-1:0] FLUSH_END = FW'(ALIGN_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [FW-1:0] flush_cnt_r;
  logic          in_ready_r;
  logic          lb_zero_r;
  logic          busy_r;
  logic          frame_done_r;

  logic [ALIGN_LAT-1:0] f_pipe_r;
  logic [XW-1:0]        cx_pipe_r [ALIGN_LAT];
  logic [YW-1:0]        cy_pipe_r [ALIGN_LAT];
  logic                 out_valid_r;
  logic [XW-1:0]        out_cx_r;
  logic [YW-1:0]        out_cy_r;

  logic accept_s;
  logic flag_s;

  assign accept_s  = bus.in_valid & in_ready_r;
  assign lb_enable = accept_s | lb_zero_r;
  assign flag_s    = (x_r >= XW'(2)) & (y_r >= YW'(2));

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_cx    = out_cx_r;
  assign bus.out_cy    = out_cy_r;
  assign lb_zero       = lb_zero_r;
  assign busy          = busy_r;
  assign frame_done    = frame_done_r;

  // Frame FSM with raster coordinate counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      x_r          <= '0;
      y_r          <= '0;
      flush_cnt_r  <= '0;
      in_ready_r   <= 1'b0;
      lb_zero_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_RUN;
            x_r        <= '0;
            y_r        <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (x_r == X_LAST) begin
              x_r <= '0;
              if (y_r == Y_LAST) begin
                y_r         <= '0;
                state_r     <= ST_FLUSH;
                in_ready_r  <= 1'b0;
                lb_zero_r   <= 1'b1;
                flush_cnt_r <= '0;
              end else begin
                y_r <= y_r + YW'(1);
              end
            end else begin
              x_r <= x_r + XW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_r == FLUSH_END) begin
            state_r      <= ST_DONE;
            lb_zero_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end else begin
            flush_cnt_r <= flush_cnt_r + FW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          lb_zero_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Interior-flag and centre pipeline; it advances only on row-buffer enables so it tracks the taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pipe_r    <= '0;
      out_valid_r <= 1'b0;
      out_cx_r    <= '0;
      out_cy_r    <= '0;
      for (int i = 0; i < ALIGN_LAT; i++) begin
        cx_pipe_r[i] <= '0;
        cy_pipe_r[i] <= '0;
      end
    end else begin
      out_valid_r <= lb_enable & f_pipe_r[ALIGN_LAT-1];
      if (lb_enable) begin
        if (f_pipe_r[ALIGN_LAT-1]) begin
          out_cx_r <= cx_pipe_r[ALIGN_LAT-1];
          out_cy_r <= cy_pipe_r[ALIGN_LAT-1];
        end
        f_pipe_r[0]  <= accept_s & flag_s;
        cx_pipe_r[0] <= x_r - XW'(1);
        cy_pipe_r[0] <= y_r - YW'(1);
        for (int i = 1; i < ALIGN_LAT; i++) begin
          f_pipe_r[i]  <= f_pipe_r[i-1];
          cx_pipe_r[i] <= cx_pipe_r[i-1];
          cy_pipe_r[i] <= cy_pipe_r[i-1];
        end
      end
    end
  end

`ifdef NMS_CTRL_STATS_EN
  logic [15:0] frame_cnt_r;
  logic [31:0] stall_cnt_r;

  assign frame_cnt = frame_cnt_r;
  assign stall_cnt = stall_cnt_r;

  // Frame counter wraps; stall counter restarts per frame and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 16'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (frame_done_r) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if ((state_r == ST_IDLE) && start) begin
        stall_cnt_r <= 32'd0;
      end else if ((state_r == ST_RUN) && !bus.in_valid && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nms_window_ctrl.sv
// Scoreboard bench for nms_window_ctrl on an 8x4 frame; stimulus pushes expected centres,
// a monitor pops them on every out_valid.
module tb_nms_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int XW = 11;
  localparam int YW = 11;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic lb_enable, lb_zero, busy, frame_done;
`ifdef NMS_CTRL_STATS_EN
  logic [15:0] frame_cnt;
  logic [31:0] stall_cnt;
`endif

  nms_window_ctrl_if #(.XW(XW), .YW(YW)) bus ();

  nms_window_ctrl #(
    .IMG_W(W), .IMG_H(H), .ALIGN_LAT(2), .XW(XW), .YW(YW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus.slave),
    .lb_enable  (lb_enable),
    .lb_zero    (lb_zero),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef NMS_CTRL_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int exp_frames = 0;
  logic [31:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // stall_mode: 0 none, 1 random 50%, 2 exactly five stalls; poke: start in RUN and FLUSH
  task automatic run_frame(input int stall_mode, input bit poke, input int abort_at);
    int n, c, stalls, p0, zcnt, done_k;
    bit v;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (x >= 2 && y >= 2) sb.push_back({16'(x - 1), 16'(y - 1)});
    p0 = pulses;
    @(posedge clk); #1;
    start = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("no_accept_with_start", {31'd0, lb_enable}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("in_ready_run", {31'd0, bus.in_ready}, 32'd1);
    check("busy_run", {31'd0, busy}, 32'd1);
`ifdef NMS_CTRL_STATS_EN
    check("stall_cnt_cleared", stall_cnt, 32'd0);
`endif
    n = 0; c = 0; stalls = 0;
    while (n < W * H && c < 400) begin
      case (stall_mode)
        1:       v = ($urandom_range(0, 1) == 1);
        2:       v = !(stalls < 5 && (c % 4) == 1);
        default: v = 1'b1;
      endcase
      if (!v) stalls++;
      bus.in_valid = v;
      start = (poke && c == 6);
      @(posedge clk); #1;
      c++;
      if (v) n++;
      if (abort_at != 0 && n == abort_at) begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        start = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_cx", 32'(bus.out_cx), 32'd0);
        check("rst_out_cy", 32'(bus.out_cy), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_lb", {30'd0, lb_enable, lb_zero}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        return;
      end
    end
    check("pixels_accepted", 32'(n), 32'(W * H));
    bus.in_valid = 1'b0;
    start = poke;
    zcnt = 0; done_k = -1;
    for (int k = 0; k < 10 && done_k < 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 0) begin
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("flush_lb_enable", {31'd0, lb_enable}, 32'd1);
      end
      if (lb_zero) zcnt++;
      if (frame_done) begin
        done_k = k;
`ifdef NMS_CTRL_STATS_EN
        check("stall_cnt_at_done", stall_cnt, 32'(stalls));
`endif
      end
    end
    check("lb_zero_cycles", 32'(zcnt), 32'd2);
    check("frame_done_time", 32'(done_k), 32'd2);
    exp_frames++;
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("pulse_count", 32'(pulses - p0), 32'((W - 2) * (H - 2)));
    check("done_one_cycle", {31'd0, frame_done}, 32'd0);
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
`ifdef NMS_CTRL_STATS_EN
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    fork
      // monitor: every out_valid must follow an enable and match the scoreboard head
      begin : monitor
        logic prev_en;
        logic [31:0] e;
        prev_en = 1'b0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            prev_en = 1'b0;
          end else begin
            if (bus.out_valid) begin
              pulses++;
              check("out_valid_after_enable", {31'd0, prev_en}, 32'd1);
              check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
              if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_cx", 32'(bus.out_cx), {16'd0, e[31:16]});
                check("out_cy", 32'(bus.out_cy), {16'd0, e[15:0]});
              end
            end
            prev_en = lb_enable;
          end
        end
      end
      begin : stimulus
        #12;
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("reset_status", {29'd0, busy, frame_done, lb_zero}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(0, 1'b0, 0);            // back-to-back pixels
        run_frame(1, 1'b0, 0);            // random stalls
        run_frame(0, 1'b1, 0);            // start ignored in RUN and FLUSH
        run_frame(0, 1'b0, 17);           // reset mid-frame
        sb.delete();
        exp_frames = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("no_done_after_abort", {31'd0, frame_done}, 32'd0);
        end
        run_frame(0, 1'b0, 0);            // clean frame after reset
        run_frame(2, 1'b0, 0);            // five injected stalls, back-to-back frame
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("in_ready_before_start", {31'd0, bus.in_ready}, 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
      end
    join
  end

endmodule
